image_line_streamer: RTL and testbench



---
 rtl/spatial_filter_pkg.sv | 28 ++
 rtl/stream_prefetch_fifo.sv | 55 +++++
 rtl/image_line_streamer.sv | 189 ++++++++++++++++++
 tb/tb_image_line_streamer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatial_filter_pkg.sv
// Shared types and sizing helpers for the spatial filter image source.
package spatial_filter_pkg;

  // Depth of the prefetch FIFO that sits between memory reads and the AXIS output.
  localparam int PREFETCH_DEPTH = 4;
  // Width of an occupancy count that can hold 0..PREFETCH_DEPTH.
  localparam int PREFETCH_CNT_W = $clog2(PREFETCH_DEPTH + 1);

  // Line streamer control states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LINE        = 2'd1,
    WAIT_CREDIT = 2'd2,
    FLUSH       = 2'd3
  } line_stream_state_t;

  // Width of the line-credit counter: enough for every credit the frame can ever hold.
  function automatic int credit_width(input int init_lines, input int image_height,
                                      input int pad_lines);
    return $clog2(init_lines + image_height + pad_lines + 1);
  endfunction

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_prefetch_fifo.sv
// Four-entry shift-register FIFO. Entry 0 is always the oldest word, so the
// head is a plain register and can drive AXIS tdata directly.
module stream_prefetch_fifo
  import spatial_filter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic                      i_pop,
  output logic [PREFETCH_CNT_W-1:0] o_count,
  output logic                      o_empty,
  output logic [WIDTH-1:0]          o_head
);

  localparam int IDX_W = width_min1(PREFETCH_DEPTH);
  localparam logic [PREFETCH_CNT_W-1:0] CNT_FULL = PREFETCH_CNT_W'(PREFETCH_DEPTH);

  logic [WIDTH-1:0]          r_entry [PREFETCH_DEPTH];
  logic [PREFETCH_CNT_W-1:0] r_count;

  logic                      w_pop;
  logic                      w_push;
  logic [PREFETCH_CNT_W-1:0] w_wr_pos;
  logic [IDX_W-1:0]          w_wr_idx;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_push   = i_push && ((r_count != CNT_FULL) || w_pop);
  // A push lands just behind the last valid entry after this cycle's shift.
  assign w_wr_pos = r_count - PREFETCH_CNT_W'(w_pop);
  assign w_wr_idx = w_wr_pos[IDX_W-1:0];

  // Shift on pop, write behind the tail on push, track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset because entry 0 is a module output that must read 0 out of reset.
      for (int i = 0; i < PREFETCH_DEPTH; i++) r_entry[i] <= '0;
      r_count <= '0;
    end else begin
      // NOTE: non-blocking assignments, so the push write below overrides the shift for the same entry.
      if (w_pop) begin
        for (int i = 0; i < PREFETCH_DEPTH - 1; i++) r_entry[i] <= r_entry[i+1];
      end
      if (w_push) r_entry[w_wr_idx] <= i_push_data;
      r_count <= r_count + PREFETCH_CNT_W'(w_push) - PREFETCH_CNT_W'(w_pop);
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = r_entry[0];

endmodule

// File: rtl/image_line_streamer.sv
// Credit-paced AXI4-Stream image source. Reads a frame row by row from a
// single-port pixel memory, appends all-zero pad rows, and only starts a new
// row while it holds a line credit from the downstream line buffer.
module image_line_streamer
  import spatial_filter_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PIXEL_SIZE   = 32,
  parameter int INIT_LINES   = 4,
  parameter int PAD_LINES    = 2,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                  axis_clk,
  input  logic                  axis_reset_n,
  input  logic                  i_start,
  input  logic                  i_intr,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [PIXEL_SIZE-1:0] i_mem_rdata,
  output logic                  o_m_data_valid,
  output logic [PIXEL_SIZE-1:0] o_m_data,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CRED_W = credit_width(INIT_LINES, IMAGE_HEIGHT, PAD_LINES);
  localparam int COL_W  = width_min1(IMAGE_WIDTH);
  localparam int ROW_W  = width_min1(IMAGE_HEIGHT + PAD_LINES + 1);
  localparam int OCC_W  = PREFETCH_CNT_W + 1;

  localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_FIRST_PAD = ROW_W'(IMAGE_HEIGHT);
  localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(IMAGE_HEIGHT + PAD_LINES - 1);
  localparam logic [CRED_W-1:0] CRED_INIT     = CRED_W'(INIT_LINES);
  localparam logic [CRED_W-1:0] CRED_MAX      = '1;

  line_stream_state_t r_state;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CRED_W-1:0]     r_credits;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_rd_vld;      // read issued last cycle; its data is on i_mem_rdata now
  logic                  r_busy;
  logic                  r_done;

  logic [PREFETCH_CNT_W-1:0] w_fifo_count;
  logic                      w_fifo_empty;
  logic [PIXEL_SIZE-1:0]     w_fifo_head;
  logic                      w_pop;
  logic                      w_push;
  logic [PIXEL_SIZE-1:0]     w_push_data;
  logic [OCC_W-1:0]          w_occupancy;
  logic                      w_slot;
  logic                      w_is_pad;
  logic                      w_in_flight;
  logic                      w_issue;
  logic                      w_pad_push;
  logic                      w_row_end;
  logic                      w_credit_inc;
  logic [CRED_W-1:0]         w_credits_next;
  logic                      w_drained;

  // A slot exists only if every word already stored or in flight still fits.
  assign w_occupancy = OCC_W'(w_fifo_count) + OCC_W'(r_mem_rd_en) + OCC_W'(r_rd_vld);
  assign w_slot      = (w_occupancy < OCC_W'(PREFETCH_DEPTH));
  assign w_in_flight = r_mem_rd_en || r_rd_vld;
  assign w_is_pad    = (r_row >= ROW_FIRST_PAD);

  // Pad words bypass memory, so they wait for outstanding reads to land to keep order.
  assign w_issue    = (r_state == LINE) && (r_credits != '0) && w_slot &&
                      (!w_is_pad || !w_in_flight);
  assign w_pad_push = w_issue && w_is_pad;
  assign w_row_end  = w_issue && (r_col == COL_LAST);

  assign w_push      = r_rd_vld || w_pad_push;
  assign w_push_data = r_rd_vld ? i_mem_rdata : '0;
  assign w_pop       = o_m_data_valid && i_m_ready;

  // Credits are only meaningful once a frame has started.
  assign w_credit_inc = i_intr && (r_state != IDLE);

  // FIFO will be empty after this edge with nothing left to arrive.
  assign w_drained = !w_in_flight &&
                     ((w_fifo_count == '0) ||
                      ((w_fifo_count == PREFETCH_CNT_W'(1)) && w_pop));

  // Next credit count: saturating increment, end-of-row decrement, both cancel.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_credits_next = r_credits;
    if (w_credit_inc && !w_row_end) begin
      if (r_credits != CRED_MAX) w_credits_next = r_credits + CRED_W'(1);
    end else if (w_row_end && !w_credit_inc) begin
      w_credits_next = r_credits - CRED_W'(1);
    end
  end

  // Control FSM plus row/column/address/credit counters and registered outputs.
  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_addr      <= '0;
      r_credits   <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_rd_vld    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_rd_vld    <= r_mem_rd_en;
      r_credits   <= w_credits_next;

      if (w_issue && !w_is_pad) begin
        r_mem_rd_en <= 1'b1;
        r_mem_addr  <= r_addr;
        r_addr      <= r_addr + ADDR_WIDTH'(1);
      end

      if (w_issue) begin
        if (w_row_end) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state   <= LINE;
            r_credits <= CRED_INIT;
            r_row     <= '0;
            r_col     <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b1;
          end
        end
        LINE: begin
          if (w_row_end) begin
            if (r_row == ROW_LAST)          r_state <= FLUSH;
            else if (w_credits_next != '0)  r_state <= LINE;
            else                            r_state <= WAIT_CREDIT;
          end
        end
        WAIT_CREDIT: begin
          if (r_credits != '0) r_state <= LINE;
        end
        FLUSH: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_prefetch_fifo #(
    .WIDTH (PIXEL_SIZE)
  ) u_prefetch (
    .clk         (axis_clk),
    .rst_n       (axis_reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_head      (w_fifo_head)
  );

  assign o_mem_rd_en    = r_mem_rd_en;
  assign o_mem_addr     = r_mem_addr;
  assign o_m_data_valid = !w_fifo_empty;
  assign o_m_data       = w_fifo_head;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_image_line_streamer.sv
// Self-checking bench for image_line_streamer on a 4x6 frame with 2 pad rows.
module tb_image_line_streamer;

  localparam int W    = 4;
  localparam int H    = 6;
  localparam int INIT = 4;
  localparam int PAD  = 2;
  localparam int PIX  = 32;
  localparam int AW   = 8;
  localparam int N_BEATS = W * (H + PAD);
  localparam int N_READS = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_intr, i_m_ready;
  logic          o_mem_rd_en;
  logic [AW-1:0] o_mem_addr;
  logic [PIX-1:0] mem_rdata = '0;
  logic          o_m_data_valid;
  logic [PIX-1:0] o_m_data;
  logic          o_busy, o_done;

  image_line_streamer #(
    .IMAGE_WIDTH (W), .IMAGE_HEIGHT (H), .PIXEL_SIZE (PIX),
    .INIT_LINES (INIT), .PAD_LINES (PAD), .ADDR_WIDTH (AW)
  ) dut (
    .axis_clk       (clk),
    .axis_reset_n   (rst_n),
    .i_start        (i_start),
    .i_intr         (i_intr),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rdata    (mem_rdata),
    .o_m_data_valid (o_m_data_valid),
    .o_m_data       (o_m_data),
    .i_m_ready      (i_m_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  int last_hs_edge = 0;
  int n_reads = 0;
  int n_done  = 0;
  logic [PIX-1:0] got [$];
  bit             stall_prev = 1'b0;
  logic [PIX-1:0] stall_data = '0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Synchronous pixel memory model: mem[i] = i + 100, data one cycle after the strobe.
  always @(posedge clk) if (o_mem_rd_en) mem_rdata <= 32'(o_mem_addr) + 32'd100;

  always @(posedge clk) edge_cnt++;

  // Mid-cycle monitor: beats, reads, done timing and stalled-beat stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid_held", o_m_data_valid, 1);
        check("stall_data_held", o_m_data, stall_data);
      end
      stall_prev = o_m_data_valid && !i_m_ready;
      stall_data = o_m_data;
      if (o_m_data_valid && i_m_ready) begin
        got.push_back(o_m_data);
        last_hs_edge = edge_cnt;
      end
      if (o_mem_rd_en) n_reads++;
      if (o_done) begin
        n_done++;
        check("done_after_last_beat", edge_cnt, last_hs_edge + 1);
        check("busy_low_at_done", o_busy, 0);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic [PIX-1:0] exp_beat(input int i);
    return (i < N_READS) ? PIX'(i + 100) : '0;
  endfunction

  task automatic clear_log();
    got.delete();
    n_reads = 0;
    n_done  = 0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; start_edge = edge_cnt; i_start = 1'b0;
  endtask

  // Land on the mid-cycle sample point of cycle k after the start edge.
  task automatic at_cycle(input int k);
    do @(negedge clk); while (edge_cnt - start_edge < k);
  endtask

  task automatic pulse_intr();
    @(posedge clk); #1; i_intr = 1'b1;
    @(posedge clk); #1; i_intr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, o_done, 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_beat_count"}, got.size(), N_BEATS);
    for (int i = 0; i < got.size() && i < N_BEATS; i++)
      check($sformatf("%s_beat%0d", tag, i), got[i], exp_beat(i));
    check({tag, "_reads"}, n_reads, N_READS);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_after"}, o_busy, 0);
  endtask

  // Full frame with credits granted after a delay, optionally with random tready.
  task automatic run_frame(input bit rand_ready, input string tag);
    bit fin = 1'b0;
    clear_log();
    i_m_ready = 1'b1;
    start_frame();
    fork
      begin
        while (!fin) begin
          @(posedge clk); #1;
          if (rand_ready) i_m_ready = 1'($urandom_range(0, 1));
        end
        i_m_ready = 1'b1;
      end
      begin
        repeat (30) @(posedge clk);
        repeat (4) pulse_intr();
        wait_done(tag);
        fin = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check_frame(tag);
  endtask

  typedef struct {
    int             cyc;
    logic           ready;
    logic           exp_rd_en;
    logic [AW-1:0]  exp_addr;
    logic           exp_valid;
    logic [PIX-1:0] exp_data;
    logic           exp_busy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{0,  1'b1, 1'b0, 8'd0,  1'b0, 32'd0,   1'b1};
    vecs[1] = '{1,  1'b1, 1'b1, 8'd0,  1'b0, 32'd0,   1'b1};
    vecs[2] = '{2,  1'b1, 1'b1, 8'd1,  1'b0, 32'd0,   1'b1};
    vecs[3] = '{3,  1'b1, 1'b1, 8'd2,  1'b1, 32'd100, 1'b1};
    vecs[4] = '{4,  1'b1, 1'b1, 8'd3,  1'b1, 32'd101, 1'b1};
    vecs[5] = '{5,  1'b1, 1'b1, 8'd4,  1'b1, 32'd102, 1'b1};
    vecs[6] = '{16, 1'b1, 1'b1, 8'd15, 1'b1, 32'd113, 1'b1};
    vecs[7] = '{17, 1'b1, 1'b0, 8'd0,  1'b1, 32'd114, 1'b1};
    vecs[8] = '{18, 1'b1, 1'b0, 8'd0,  1'b1, 32'd115, 1'b1};
    vecs[9] = '{19, 1'b1, 1'b0, 8'd0,  1'b0, 32'd0,   1'b1};

    rst_n = 1'b0; i_start = 1'b0; i_intr = 1'b0; i_m_ready = 1'b0;

    // Reset held with random inputs: every output stays low.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      i_start   = 1'($urandom_range(0, 1));
      i_intr    = 1'($urandom_range(0, 1));
      i_m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_outputs", {o_mem_rd_en, o_mem_addr, o_m_data_valid, o_m_data, o_busy, o_done}, '0);
    end
    @(posedge clk); #1;
    i_start = 1'b0; i_intr = 1'b0; i_m_ready = 1'b1; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_reads", n_reads, 0);
    check("idle_not_busy", o_busy, 0);
    check("idle_no_valid", o_m_data_valid, 0);

    // Initial credits: latency, one beat per cycle, stall after four rows.
    clear_log();
    start_frame();
    for (int v = 0; v < 10; v++) begin
      at_cycle(vecs[v].cyc);
      i_m_ready = vecs[v].ready;
      check($sformatf("c%0d_rd_en", vecs[v].cyc), o_mem_rd_en, vecs[v].exp_rd_en);
      if (vecs[v].exp_rd_en) check($sformatf("c%0d_addr", vecs[v].cyc), o_mem_addr, vecs[v].exp_addr);
      check($sformatf("c%0d_valid", vecs[v].cyc), o_m_data_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check($sformatf("c%0d_data", vecs[v].cyc), o_m_data, vecs[v].exp_data);
      check($sformatf("c%0d_busy", vecs[v].cyc), o_busy, vecs[v].exp_busy);
    end
    at_cycle(30);
    check("s2_beats_before_credit", got.size(), 16);
    check("s2_reads_before_credit", n_reads, 16);
    check("s2_last_beat_cycle", last_hs_edge - start_edge, 18);
    check("s2_busy_while_waiting", o_busy, 1);
    check("s2_no_read_while_waiting", o_mem_rd_en, 0);

    // Completion: four credits release the last image rows and the padding.
    repeat (4) pulse_intr();
    wait_done("s3");
    repeat (10) @(negedge clk);
    check_frame("s3");

    // Random backpressure: identical beat sequence, stalled beats stay stable.
    run_frame(1'b1, "s4");

    // Credit arriving on the end-of-row edge while one credit remains.
    clear_log();
    i_m_ready = 1'b1;
    start_frame();
    at_cycle(15); i_intr = 1'b1;
    at_cycle(16); i_intr = 1'b0;
    at_cycle(17);
    check("s5_next_row_rd_en", o_mem_rd_en, 1);
    check("s5_next_row_addr", o_mem_addr, 16);
    at_cycle(20);
    check("s5_row4_last_rd_en", o_mem_rd_en, 1);
    check("s5_row4_last_addr", o_mem_addr, 19);
    at_cycle(21);
    check("s5_stall_after_row4", o_mem_rd_en, 0);
    repeat (3) pulse_intr();
    wait_done("s5");
    repeat (10) @(negedge clk);
    check_frame("s5");

    // Reset in the middle of row 2, then a clean restart.
    clear_log();
    start_frame();
    at_cycle(10);
    rst_n = 1'b0;
    @(negedge clk);
    check("s6_reset_outputs", {o_mem_rd_en, o_mem_addr, o_m_data_valid, o_m_data, o_busy, o_done}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_frame(1'b0, "s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
